// File: rtl/hog_src_pkg.sv
// Shared types and helpers for the HOG upstream pixel source.
// Output state enum, default timing constants, counter width helper.
package hog_src_pkg;

   typedef enum logic {
      SRC_IDLE = 1'b0,
      SRC_HOLD = 1'b1
   } src_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 100000;
   localparam int DEF_AUTO_INTERVAL   = 16;

   function automatic int clog2_min1(input int n);
      int r;
      r = $clog2(n);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and stability-count debouncer for an active-low key.
// Emits one registered pulse per debounced press once a release has been seen.
module key_debounce
   import hog_src_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_db,
   output logic press_pulse
);

   localparam int CW = clog2_min1(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_key_db;
   logic          r_prev;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_fill;
   logic          r_armed;
   logic          r_pulse;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1     <= 1'b1;
         r_s2     <= 1'b1;
         r_key_db <= 1'b1;
         r_cnt    <= '0;
      end else begin
         r_s1 <= key_n;
         r_s2 <= r_s1;
         if (r_s2 != r_key_db) begin
            if (r_cnt == CNT_LAST) begin
               r_key_db <= r_s2;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   // A key held through reset must be released before it can fire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev  <= 1'b1;
         r_fill  <= 2'b00;
         r_armed <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_prev  <= r_key_db;
         r_fill  <= {r_fill[0], 1'b1};
         r_armed <= r_armed | (r_fill[1] & r_key_db & r_s2);
         r_pulse <= r_prev & ~r_key_db & r_armed;
      end
   end

   assign key_db      = r_key_db;
   assign press_pulse = r_pulse;

endmodule

// File: rtl/key_pixel_source.sv
// Key/switch driven valid-ready pixel source with an auto ramp mode.
// Feeds the HOG wrapper input port in the slow clock domain.
module key_pixel_source
   import hog_src_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int AUTO_INTERVAL   = DEF_AUTO_INTERVAL,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_n,
   input  logic [DATA_WIDTH-1:0] sw_data,
   input  logic                  auto_en,
   output logic [DATA_WIDTH-1:0] pixel_out,
   output logic                  pixel_valid,
   input  logic                  pixel_ready,
   output logic [CNT_WIDTH-1:0]  pixel_count,
   output logic                  overrun,
   output logic                  backpressure
);

   localparam int AW = clog2_min1(AUTO_INTERVAL);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_INTERVAL - 1);

   logic                  r_auto_s1;
   logic                  r_auto_s2;
   logic [DATA_WIDTH-1:0] r_sw_s1;
   logic [DATA_WIDTH-1:0] r_sw_s2;
   logic [AW-1:0]         r_auto_cnt;
   logic                  r_auto_evt;
   src_state_t            r_state;
   logic [DATA_WIDTH-1:0] r_out;
   logic [CNT_WIDTH-1:0]  r_count;
   logic                  r_ovr;

   logic                  w_key_db;
   logic                  w_press;
   logic                  w_man_evt;
   logic                  w_evt;
   logic [DATA_WIDTH-1:0] w_evt_data;
   src_state_t            w_state_nxt;
   logic                  w_load;
   logic                  w_ovr_set;
   logic                  w_xfer;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_n),
      .key_db      (w_key_db),
      .press_pulse (w_press)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_auto_s1 <= 1'b0;
         r_auto_s2 <= 1'b0;
         r_sw_s1   <= '0;
         r_sw_s2   <= '0;
      end else begin
         r_auto_s1 <= auto_en;
         r_auto_s2 <= r_auto_s1;
         r_sw_s1   <= sw_data;
         r_sw_s2   <= r_sw_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_auto_cnt <= '0;
         r_auto_evt <= 1'b0;
      end else begin
         r_auto_evt <= r_auto_s2 && (r_auto_cnt == AUTO_LAST);
         if (!r_auto_s2 || r_auto_cnt == AUTO_LAST) begin
            r_auto_cnt <= '0;
         end else begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
         end
      end
   end

   assign w_man_evt  = w_press & ~w_key_db & ~r_auto_s2;
   assign w_evt      = w_man_evt | r_auto_evt;
   assign w_evt_data = r_auto_evt ? r_count[DATA_WIDTH-1:0] : r_sw_s2;
   assign w_xfer     = (r_state == SRC_HOLD) & pixel_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_ovr_set   = 1'b0;
      unique case (r_state)
         SRC_IDLE: begin
            if (w_evt) begin
               w_load      = 1'b1;
               w_state_nxt = SRC_HOLD;
            end
         end
         SRC_HOLD: begin
            if (pixel_ready) begin
               if (w_evt) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = SRC_IDLE;
               end
            end else if (w_evt) begin
               w_ovr_set = 1'b1;
            end
         end
         default: w_state_nxt = SRC_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SRC_IDLE;
         r_out   <= '0;
         r_count <= '0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_out <= w_evt_data;
         end
         if (w_xfer) begin
            r_count <= r_count + 1'b1;
         end
         if (w_ovr_set) begin
            r_ovr <= 1'b1;
         end
      end
   end

   assign pixel_out    = r_out;
   assign pixel_valid  = (r_state == SRC_HOLD);
   assign pixel_count  = r_count;
   assign overrun      = r_ovr;
   assign backpressure = pixel_valid & ~pixel_ready;

endmodule

// File: doc/key_pixel_source.md
# key_pixel_source

Upstream pixel source for the HOG wrapper on the DE1-SoC. It turns an 8-bit switch bank and a raw, bouncy, active-low push-button into a clean valid/ready pixel stream. Each debounced press produces exactly one pixel. An auto mode instead streams a ramp at a fixed interval for throughput testing. It sits between the board I/O and the wrapper's `input_pixel`/`pixel_valid`/`pixel_ready` ports, in the slow clock domain.

## Interface

Parameters:
- `DATA_WIDTH`, 8: pixel width.
- `DEBOUNCE_CYCLES`, 100000: consecutive stable cycles needed to accept a key level change (10 ms at 10 MHz). Must be ≥ 2.
- `AUTO_INTERVAL`, 16: cycles between auto-mode pixel events. Must be ≥ 2.
- `CNT_WIDTH`, 16: width of the handshake counter.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_n`  in  1  raw push-button, 0 = pressed, asynchronous to `clk`.
- `sw_data`  in  DATA_WIDTH  raw switches, quasi-static, asynchronous.
- `auto_en`  in  1  raw switch selecting auto mode, asynchronous.
- `pixel_out`  out  DATA_WIDTH  pixel data.
- `pixel_valid`  out  1  `pixel_out` holds a pixel.
- `pixel_ready`  in  1  consumer accepts the pixel.
- `pixel_count`  out  CNT_WIDTH  completed handshakes, wraps.
- `overrun`  out  1  sticky: an event was dropped while holding a pixel.
- `backpressure`  out  1  `pixel_valid && !pixel_ready`.

## Operation

- **Synchronisation.** `key_n`, `auto_en` and `sw_data` each pass through 2 flops. Reset values: key 1, auto 0, data 0.
- **Debounce.**
  - `key_db` resets to 1 (released).
  - A counter runs while the synchronised key differs from `key_db`. It clears to 0 whenever they agree.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, `key_db` takes the new level on the next edge and the counter clears.
- **Events.**
  - Manual event: a one-cycle pulse on the `key_db` 1→0 transition. Data is the synchronised `sw_data`.
  - Release (0→1) generates no event.
  - While synchronised `auto_en` is 1, manual events are ignored.
- **Auto mode.**
  - The interval counter counts 0 to `AUTO_INTERVAL-1` and wraps.
  - An auto event fires on every wrap. Data is `pixel_count[DATA_WIDTH-1:0]` at event time, which produces a ramp.
  - The counter is held at 0 while auto mode is off.
- **Output state machine.** States are `IDLE` (valid 0) and `HOLD` (valid 1).
  - `IDLE` + event → load `pixel_out`, go to `HOLD`.
  - `HOLD` + `pixel_ready` with no event → go to `IDLE`. `pixel_out` keeps its last value.
  - `HOLD` + `pixel_ready` + event same cycle → load new data, stay in `HOLD` (back-to-back transfer, no bubble).
  - `HOLD` + event without `pixel_ready` → drop the event, set `overrun`. `pixel_out` is unchanged.
- **Stability rule.** `pixel_out` must not change while `pixel_valid && !pixel_ready`.
- **Counter.** `pixel_count` increments by 1 on each cycle with `pixel_valid && pixel_ready` and wraps modulo 2^CNT_WIDTH.
- **Overrun.** `overrun` clears only on reset.

## Timing

- **Reset values.** `pixel_valid` 0, `pixel_out` 0, `pixel_count` 0, `overrun` 0, `backpressure` 0. All internal counters 0. `key_db` 1.
- **Reset behaviour.** Reset assertion mid-transfer drops the held pixel immediately (asynchronously). No event is generated on reset release, even if the key is held; the press must be released and pressed again.
- **Key latency.** With `key_n` held low from the clock edge that first samples it low (edge 0), `pixel_valid` rises at edge `DEBOUNCE_CYCLES+3`. Breakdown: 2 cycles sync, `DEBOUNCE_CYCLES` stability, 1 cycle load.
- **Bounce.** A bounce shorter than `DEBOUNCE_CYCLES` cycles restarts stability counting and produces no event.
- **Auto latency.**
  - The first auto event fires `AUTO_INTERVAL` cycles after synchronised `auto_en` rises.
  - `pixel_valid` follows 1 cycle later.
  - Disabling auto mode takes effect after sync. A pixel already in `HOLD` is still delivered.
- **Handshake.** `pixel_ready` is sampled on the same edge that updates state. There is no combinational path from `pixel_ready` to `pixel_out` or `pixel_valid`. `backpressure` is combinational.

## Structure

- **Package `hog_src_pkg`.**
  - State enum: `SRC_IDLE`, `SRC_HOLD`.
  - Default constants: `DEBOUNCE_CYCLES`, `AUTO_INTERVAL`.
  - Function `clog2_min1` for counter widths.
- **Sub-module `key_debounce`.**
  - Contains the 2-flop sync and the debounce counter.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst_n`, `key_n`, `key_db`, `press_pulse`.
- **Top level.** Data sync, auto timer, output state machine and counters stay in the top level.

## Test plan

- **Clean press.** Set `DEBOUNCE_CYCLES`=4, `sw_data`=0xA5, `pixel_ready`=1, then hold `key_n` low → `pixel_valid` high for exactly 1 cycle at edge 7 with `pixel_out`=0xA5, `pixel_count`=1.
- **Bouncy press.** `key_n` toggles low 3 cycles / high 2 cycles, 5 times, then stays low → exactly one pixel. Release with bounce → no pixel.
- **Backpressure and overrun.** `pixel_ready`=0, press twice → first pixel held stable, `backpressure`=1, `overrun`=1 after the second press, `pixel_count`=0. Raise ready → one handshake, `pixel_count`=1.
- **Auto stream.** `AUTO_INTERVAL`=4, `auto_en`=1, ready=1 → `pixel_out` 0x00, 0x01, 0x02… every 4 cycles. Key presses are ignored.
- **Back-to-back.** `AUTO_INTERVAL`=2, ready toggled so that an event coincides with a handshake → new pixel loaded with no idle cycle and no overrun.
- **Reset mid-hold.** Drop `rst_n` while `pixel_valid`=1 → all outputs 0 immediately. Release reset with key held → no pixel until re-press.
